// File: rtl/pkg_conversores.sv
// Shared definitions for the number-format converters.
//   N_DIGITOS_PADRAO   : default number of packed BCD digits
//   LARGURA_BIN_PADRAO : default binary width / iteration count
//   BCD_MAX_DIGITO     : largest legal value of a BCD nibble
//   estado_t           : control states of the sequential converter
package pkg_conversores;

  localparam int N_DIGITOS_PADRAO = 3;
  localparam int LARGURA_BIN_PADRAO = 10;
  localparam logic [3:0] BCD_MAX_DIGITO = 4'd9;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    PRONTO   = 2'd2
  } estado_t;

endpackage

// File: rtl/corretor_digito_bcd.sv
// Per-digit correction step of reverse double-dabble.
// After a right shift, a digit of 8 or more carries a half-weight
// of 8 that must read as 5 in decimal, so 3 is removed.
// Ports:
//   digito    : 4-bit digit after the shift
//   corrigido : corrected digit (digito - 3 when digito >= 8)
module corretor_digito_bcd (
  input  logic [3:0] digito,
  output logic [3:0] corrigido
);

  assign corrigido = (digito >= 4'd8) ? (digito - 4'd3) : digito;

endmodule

// File: rtl/bcd_para_binario.sv
// Sequential BCD-to-binary converter, one shift per clock.
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   start    : conversion request, sampled only in OCIOSO
//   bcd_in   : packed digits, most significant digit in the top nibble
//   binario  : result, held until the next accepted request
//   ocupado  : high while converting
//   pronto   : one-cycle completion pulse
//   erro     : last accepted request had a nibble above 9
//   estado   : current control state, for observation
//
// Handshake: a request is accepted on a rising edge where start=1 and
// the FSM is in OCIOSO. Exactly one pronto pulse follows every accepted
// request; start is ignored at any other time, nothing is queued.
module bcd_para_binario
  import pkg_conversores::*;
#(
  parameter int N_DIGITOS   = N_DIGITOS_PADRAO,
  parameter int LARGURA_BIN = LARGURA_BIN_PADRAO
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [4*N_DIGITOS-1:0] bcd_in,
  output logic [LARGURA_BIN-1:0] binario,
  output logic                   ocupado,
  output logic                   pronto,
  output logic                   erro,
  output estado_t                estado
);

  localparam int LARGURA_BCD = 4 * N_DIGITOS;
  localparam int LARGURA_SR  = LARGURA_BCD + LARGURA_BIN;
  localparam int LARGURA_CNT = (LARGURA_BIN > 1) ? $clog2(LARGURA_BIN) : 1;
  localparam logic [LARGURA_CNT-1:0] ULTIMA_ITER = LARGURA_CNT'(LARGURA_BIN - 1);

  estado_t estado_q, estado_d;

  // sr: BCD field on top, binary result assembled from the MSB side
  // of the lower field as digits are shifted down.
  logic [LARGURA_SR-1:0]  sr;
  logic [LARGURA_SR-1:0]  sr_desl;
  logic [LARGURA_SR-1:0]  sr_corr;
  logic [LARGURA_BCD-1:0] bcd_corr;
  logic [LARGURA_CNT-1:0] contador;
  logic                   digito_invalido;
  logic                   ultima;

  always_comb begin
    digito_invalido = 1'b0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (bcd_in[4*i +: 4] > BCD_MAX_DIGITO) digito_invalido = 1'b1;
    end
  end

  assign sr_desl = {1'b0, sr[LARGURA_SR-1:1]};

  for (genvar g = 0; g < N_DIGITOS; g++) begin : g_corretor
    corretor_digito_bcd u_corretor (
      .digito    (sr_desl[LARGURA_BIN + 4*g +: 4]),
      .corrigido (bcd_corr[4*g +: 4])
    );
  end

  assign sr_corr = {bcd_corr, sr_desl[LARGURA_BIN-1:0]};
  assign ultima  = (contador == ULTIMA_ITER);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado_q <= OCIOSO;
    else          estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:   if (start) estado_d = digito_invalido ? PRONTO : CONVERTE;
      CONVERTE: if (ultima) estado_d = PRONTO;
      PRONTO:   estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr       <= '0;
      contador <= '0;
      binario  <= '0;
      erro     <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (start) begin
            if (digito_invalido) begin
              // Rejected request completes at once with a zero result.
              erro    <= 1'b1;
              binario <= '0;
            end else begin
              erro     <= 1'b0;
              sr       <= {bcd_in, {LARGURA_BIN{1'b0}}};
              contador <= '0;
            end
          end
        end
        CONVERTE: begin
          sr       <= sr_corr;
          contador <= contador + LARGURA_CNT'(1);
          if (ultima) binario <= sr_corr[LARGURA_BIN-1:0];
        end
        default: ;
      endcase
    end
  end

  assign ocupado = (estado_q == CONVERTE);
  assign pronto  = (estado_q == PRONTO);
  assign estado  = estado_q;

endmodule
